sici_tx_ctrl: RTL and testbench

Transmit-side link controller for the SICI source-synchronous serial link. It generates the two 8-bit parallel words per `pclk` that feed the external 8:1 serializers: one for the data lane and one for the forwarded-clock lane. It runs the link-training sequence the far-end receiver needs for its delay calibration, then a sync preamble, then carries PCS bytes through a valid/ready handshake. A calibration-lost or re-calibration request sends it back to training.

---
 rtl/sici_pkg.sv | 35 +++
 rtl/sici_prbs8.sv | 29 ++
 rtl/sici_tx_ctrl.sv | 134 +++++++++++++
 tb/tb_sici_tx_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sici_pkg.sv
// Shared definitions for the SICI transmit controller: FSM encoding, default
// lane words and the PRBS7 helper used by the optional idle scrambler.
package sici_pkg;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_TRAIN = 2'd1,
        S_SYNC  = 2'd2,
        S_DATA  = 2'd3
    } sici_state_e;

    localparam logic [7:0] DEF_TRAIN_PAT = 8'hF0;
    localparam logic [7:0] DEF_CLK_PAT   = 8'h55;
    localparam logic [7:0] DEF_SYNC_WORD = 8'hBC;
    localparam logic [7:0] DEF_IDLE_WORD = 8'h3C;

    // x^7 + x^6 + 1: feedback taps on bits 6 and 5 of the shift register
    localparam logic [6:0] PRBS7_POLY = 7'b110_0000;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // Advances the PRBS7 register by 8 bits. Returns {byte, next_state}, where
    // the byte is emitted MSB first (bit 7 is the first bit shifted out).
    function automatic logic [14:0] prbs7_step8(input logic [6:0] s_in);
        logic [6:0] s;
        logic [7:0] b;
        s = s_in;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            b[i] = s[6];
            s    = {s[5:0], ^(s & PRBS7_POLY)};
        end
        return {b, s};
    endfunction

endpackage

// File: rtl/sici_prbs8.sv
// PRBS7 generator producing one 8-bit word per cycle; word shows the byte the
// next advance will consume. seed_load has priority over adv.
module sici_prbs8
    import sici_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic       adv,
    output logic [7:0] word
);

    logic [6:0]  lfsr;
    logic [14:0] step;

    assign step = prbs7_step8(lfsr);
    assign word = step[14:7];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= PRBS7_SEED;
        end else if (seed_load) begin
            lfsr <= PRBS7_SEED;
        end else if (adv) begin
            lfsr <= step[6:0];
        end
    end

endmodule

// File: rtl/sici_tx_ctrl.sv
// SICI transmit link controller: training, sync preamble, then PCS data.
// Optional PRBS7 idle fill is enabled by defining SICI_TX_PRBS_EN.
module sici_tx_ctrl
    import sici_pkg::*;
#(
    parameter int         TRAIN_LEN = 256,
    parameter int         SYNC_LEN  = 4,
    parameter logic [7:0] TRAIN_PAT = DEF_TRAIN_PAT,
    parameter logic [7:0] CLK_PAT   = DEF_CLK_PAT,
    parameter logic [7:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [7:0] IDLE_WORD = DEF_IDLE_WORD
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       peer_cal,
    input  logic       recal,
    output logic [7:0] d_q,
    output logic [7:0] ck_q,
    output logic       training,
    output logic       link_ok
);

    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam logic [TW-1:0] TRAIN_MAX = TW'(TRAIN_LEN);
    localparam logic [SW-1:0] SYNC_MAX  = SW'(SYNC_LEN);

    localparam logic [1:0] ST_RST   = S_RST;
    localparam logic [1:0] ST_TRAIN = S_TRAIN;
    localparam logic [1:0] ST_SYNC  = S_SYNC;
    localparam logic [1:0] ST_DATA  = S_DATA;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] train_cnt;
    logic [SW-1:0] sync_cnt;
    logic          accept;
    logic          train_restart;
    logic [7:0]    idle_fill;

    // Handshake: a beat transfers when tx_valid && tx_ready on a pclk edge.
    // tx_ready is combinational and drops with recal/peer_cal loss, so a beat
    // is never accepted in the cycle the link leaves DATA.
    assign tx_ready = (state == ST_DATA) && peer_cal && !recal;
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_TRAIN;
            ST_TRAIN: begin
                if (!recal && peer_cal && (train_cnt == TRAIN_MAX))
                    state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (recal || !peer_cal)
                    state_nxt = ST_TRAIN;
                else if (sync_cnt == SYNC_MAX)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (recal || !peer_cal)
                    state_nxt = ST_TRAIN;
            end
            default:  state_nxt = ST_TRAIN;
        endcase
    end

    assign train_restart = (state_nxt == ST_TRAIN) && ((state != ST_TRAIN) || recal);

`ifdef SICI_TX_PRBS_EN
    sici_prbs8 u_prbs (
        .clk       (pclk),
        .rst       (rst),
        .seed_load ((state_nxt == ST_DATA) && (state != ST_DATA)),
        .adv       ((state == ST_DATA) && (state_nxt == ST_DATA) && !accept),
        .word      (idle_fill)
    );
`else
    assign idle_fill = IDLE_WORD;
`endif

    // Counters hold the number of words of the current phase already on d_q,
    // so the word launched on the entry edge counts as 1.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state     <= ST_RST;
            train_cnt <= '0;
            sync_cnt  <= '0;
            d_q       <= 8'h00;
            ck_q      <= 8'h00;
            training  <= 1'b0;
            link_ok   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ck_q     <= CLK_PAT;
            training <= (state_nxt == ST_TRAIN);
            link_ok  <= (state_nxt == ST_DATA);

            if (state_nxt != ST_TRAIN)
                train_cnt <= '0;
            else if (train_restart)
                train_cnt <= TW'(1);
            else if (train_cnt != TRAIN_MAX)
                train_cnt <= train_cnt + TW'(1);

            if (state_nxt != ST_SYNC)
                sync_cnt <= '0;
            else if (state != ST_SYNC)
                sync_cnt <= SW'(1);
            else if (sync_cnt != SYNC_MAX)
                sync_cnt <= sync_cnt + SW'(1);

            case (state_nxt)
                ST_TRAIN: d_q <= TRAIN_PAT;
                ST_SYNC:  d_q <= SYNC_WORD;
                ST_DATA: begin
                    // The entry word is plain idle; no beat can be accepted in SYNC.
                    if (state != ST_DATA)
                        d_q <= IDLE_WORD;
                    else if (accept)
                        d_q <= tx_data;
                    else
                        d_q <= idle_fill;
                end
                default:  d_q <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sici_tx_ctrl.sv
// Directed scoreboard bench for sici_tx_ctrl with TRAIN_LEN=8, SYNC_LEN=4.
module tb_sici_tx_ctrl;

    logic       pclk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       peer_cal;
    logic       recal;
    logic [7:0] d_q;
    logic [7:0] ck_q;
    logic       training;
    logic       link_ok;

    logic [18:0] exp_q[$];
    string       phase;
    int          vectors;
    int          miscompares;
    int          cyc_n;

    sici_tx_ctrl #(
        .TRAIN_LEN (8),
        .SYNC_LEN  (4)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .peer_cal (peer_cal),
        .recal    (recal),
        .d_q      (d_q),
        .ck_q     (ck_q),
        .training (training),
        .link_ok  (link_ok)
    );

    // clock / reset defaults
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // expected word: {d_q, ck_q, training, link_ok, tx_ready}
    function automatic logic [18:0] e(input logic [7:0] d, input logic ck_on,
                                      input logic tr, input logic ok, input logic rdy);
        return {d, (ck_on ? 8'h55 : 8'h00), tr, ok, rdy};
    endfunction

    // Drives the inputs for one cycle and records what the outputs must read
    // in that cycle (registered outputs reflect the previous cycle's inputs).
    task automatic cyc(input string ph, input logic r, input logic v, input logic [7:0] d,
                       input logic pc, input logic rc, input logic [18:0] ex);
        @(posedge pclk);
        #1;
        rst      = r;
        tx_valid = v;
        tx_data  = d;
        peer_cal = pc;
        recal    = rc;
        phase    = ph;
        cyc_n++;
        exp_q.push_back(ex);
    endtask

    // scoreboard monitor
    always @(negedge pclk) begin
        if (exp_q.size() != 0) begin
            logic [18:0] ex;
            logic [18:0] act;
            ex  = exp_q.pop_front();
            act = {d_q, ck_q, training, link_ok, tx_ready};
            vectors++;
            if (act !== ex) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got d_q=%h ck_q=%h training=%b link_ok=%b tx_ready=%b, want d_q=%h ck_q=%h training=%b link_ok=%b tx_ready=%b",
                         phase, cyc_n, act[18:11], act[10:3], act[2], act[1], act[0],
                         ex[18:11], ex[10:3], ex[2], ex[1], ex[0]);
            end
        end
    end

    initial begin
        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; peer_cal = 1'b1; recal = 1'b0;
        phase = "init"; vectors = 0; miscompares = 0; cyc_n = 0;

        repeat (3) cyc("reset", 0, 0, 8'h00, 1, 0, e(8'h00, 0, 0, 0, 0));
        cyc("release", 1, 0, 8'h00, 1, 0, e(8'h00, 0, 0, 0, 0));

        // bring-up: cycles 1..8 training, 9..12 sync, 13 link up
        repeat (8) cyc("bringup_train", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));
        repeat (4) cyc("bringup_sync", 1, 0, 8'h00, 1, 0, e(8'hBC, 1, 0, 0, 0));

        // data path with one-cycle latency, then idle fill
        cyc("data_in1", 1, 1, 8'h01, 1, 0, e(8'h3C, 1, 0, 1, 1));
        cyc("data_in2", 1, 1, 8'h02, 1, 0, e(8'h01, 1, 0, 1, 1));
        cyc("data_in3", 1, 1, 8'h03, 1, 0, e(8'h02, 1, 0, 1, 1));
        cyc("data_out3", 1, 0, 8'h00, 1, 0, e(8'h03, 1, 0, 1, 1));
        repeat (2) cyc("data_idle", 1, 0, 8'h00, 1, 0, e(8'h3C, 1, 0, 1, 1));

        // recal during traffic: byte AA must never appear
        cyc("recal_data", 1, 1, 8'hAA, 1, 1, e(8'h3C, 1, 0, 1, 0));

        // held training with peer_cal low, then rise -> sync next cycle
        repeat (100) cyc("held_train", 1, 0, 8'h00, 0, 0, e(8'hF0, 1, 1, 0, 0));
        cyc("cal_rise", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));
        cyc("sync1", 1, 0, 8'h00, 1, 0, e(8'hBC, 1, 0, 0, 0));

        // link loss in the second sync cycle -> full retrain
        cyc("sync2_loss", 1, 0, 8'h00, 0, 0, e(8'hBC, 1, 0, 0, 0));
        repeat (7) cyc("retrain", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));

        // recal coinciding with the training exit condition restarts training
        cyc("recal_at_exit", 1, 0, 8'h00, 1, 1, e(8'hF0, 1, 1, 0, 0));
        repeat (8) cyc("train_after_recal", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));
        repeat (4) cyc("sync_after_recal", 1, 0, 8'h00, 1, 0, e(8'hBC, 1, 0, 0, 0));

        // transparent bytes equal to sync/idle words
        cyc("transparent1", 1, 1, 8'hBC, 1, 0, e(8'h3C, 1, 0, 1, 1));
        cyc("transparent2", 1, 1, 8'h3C, 1, 0, e(8'hBC, 1, 0, 1, 1));
        cyc("transparent_out", 1, 0, 8'h00, 1, 0, e(8'h3C, 1, 0, 1, 1));

        // peer_cal loss in DATA with a pending beat
        cyc("loss_data", 1, 1, 8'h77, 0, 0, e(8'h3C, 1, 0, 1, 0));
        repeat (8) cyc("train_after_loss", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));
        repeat (4) cyc("sync_after_loss", 1, 0, 8'h00, 1, 0, e(8'hBC, 1, 0, 0, 0));

        // mid-run reset: in-flight beat 66 dropped
        cyc("pre_reset", 1, 1, 8'h5A, 1, 0, e(8'h3C, 1, 0, 1, 1));
        cyc("reset_assert", 0, 1, 8'h66, 1, 0, e(8'h5A, 1, 0, 1, 1));
        cyc("reset_held", 0, 0, 8'h00, 1, 0, e(8'h00, 0, 0, 0, 0));
        cyc("reset_release", 1, 0, 8'h00, 1, 0, e(8'h00, 0, 0, 0, 0));
        repeat (3) cyc("restart_train", 1, 0, 8'h00, 1, 0, e(8'hF0, 1, 1, 0, 0));

        @(negedge pclk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
